pheap_req_sched: RTL and testbench
==================================

// Module: pheap_req_sched
// PURPOSE
// Front-end scheduler for the pHeap root level (level 1). Arbitrates ENQ (LEQ) and DEQ requests from
// NREQ requesters round-robin and sequences the level-1 start/op/in handshake until done leaves WAIT.
// Screens ENQ-when-full and DEQ-when-empty, paces issue for the lower pipelined levels, and returns
// dequeued kv_t to the granted requester.
// PARAMETERS
// NREQ       4    number of requesters, >=2
// ISSUE_GAP  2    idle cycles after a completed op before the next grant (lower-level drain), >=0
// TIMEOUT    15   EXEC cycles with done==WAIT before a watchdog error, >=1
// PORTS
// clk         in   1          clock
// rst         in   1          synchronous active-high reset
// req_valid   in   NREQ       request pending per requester
// req_op      in   NREQ x op  opcode_t per requester (LEQ or DEQ)
// req_kv      in   NREQ x kv  kv_t to enqueue (ignored for DEQ)
// req_ready   out  NREQ       one-hot grant, combinational, IDLE only
// resp_valid  out  NREQ       one-hot 1-cycle completion pulse to the granted requester
// resp_kv     out  kv         dequeued kv_t, or KV_EMPTY
// resp_err    out  1          qualifies resp_valid: 1 = rejected or timed out
// start       out  1          level-1 start pulse
// op          out  op         opcode_t to level 1
// in          out  kv         kv_t to level 1
// done        in   done       done_t from level 1 (WAIT / NEXT_LEVEL / DONE)
// out         in   kv         level-1 out (valid in the EXEC cycle)
// full,empty  in   1          level-1 capacity flags
// busy        out  1          state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, gap/watchdog counters=0, all outputs 0 or KV_EMPTY.
// - rst mid-operation drops the captured request and emits no resp_valid; the requester re-presents it.
// - FSM states: IDLE, ISSUE, EXEC, GAP.
// - IDLE:
//   - Grant the first req_valid at or after rr_ptr, cyclically; req_ready=onehot(g).
//   - On grant: capture g, op and kv into registers; rr_ptr <= (g+1) mod NREQ.
//   - Screen: LEQ&&full, DEQ&&empty, or any other opcode -> do not issue. Next cycle resp_valid[g]=1,
//     resp_err=1, resp_kv=KV_EMPTY; go to GAP if ISSUE_GAP>0, else IDLE.
//   - Accepted -> ISSUE.
// - ISSUE (1 cycle): start=1; op/in driven from the capture registers -> EXEC.
// - EXEC: start=0; op/in held unchanged.
//   - done!=WAIT: register out (DEQ) or KV_EMPTY (LEQ) into resp_kv. Next cycle resp_valid[g]=1,
//     resp_err=0.
//   - Watchdog counts WAIT cycles; reaching TIMEOUT -> resp_err=1, resp_kv=KV_EMPTY.
//   - Either way -> GAP (or IDLE if ISSUE_GAP==0).
// - GAP: count ISSUE_GAP cycles with req_ready=0, then IDLE.
// - Outside ISSUE/EXEC: op=LEQ, in=KV_EMPTY (level 1 ignores them without start).
// - Latency, accepted op: grant c0, start c1, level-1 execute c2, resp_valid c3, next grant earliest c4+ISSUE_GAP.
// - Latency, rejected op: resp_valid c1.
// - Level-1 NEXT_LEVEL and DONE are both completion; lower levels proceed independently.
// - full/empty are sampled in the grant cycle; the flags are current because the previous op has
//   finished level 1.
// - req_valid dropping after grant has no effect.
// - Simultaneous requests: exactly one grant per IDLE cycle; ungranted requesters wait.
// - Fairness: each requester is granted within NREQ grants.
// - resp_valid and req_ready are never asserted in the same cycle.
// STRUCTURE
// - pheapTypes gains sched_state_t {IDLE,ISSUE,EXEC,GAP}.
// - opcode_t, done_t, kv_t, KV_EMPTY, LEQ/DEQ and WAIT/DONE/NEXT_LEVEL are reused from
//   pq_pkg/pheapTypes.
// - Sub-module rr_arbiter #(N) (req, ptr -> onehot grant, index) is split out so it can be reused
//   by the level memories.
// - Counters are sized $clog2(ISSUE_GAP+1) and $clog2(TIMEOUT+1).
// TESTING
// - Reset, req0 LEQ key=0x10, level-1 model done=DONE at c2 -> start only at c1, op=LEQ, in.key=0x10;
//   resp_valid[0] at c3, err=0.
// - req1,req3 LEQ simultaneously, rr_ptr=0 -> grant 1 then 3; rr_ptr=0 afterwards; no grant during
//   GAP (2 cycles).
// - empty=1, req2 DEQ -> no start; resp_valid[2] next cycle, err=1, resp_kv=KV_EMPTY.
// - full=1, req0 LEQ -> rejected, err=1.
// - full=1, then req0 DEQ with out.key=0x55, done=NEXT_LEVEL -> resp_kv.key=0x55, err=0.
// - done held WAIT for 15 EXEC cycles -> resp_err=1 at cycle 16, FSM returns to IDLE via GAP.
// - rst asserted in EXEC -> no resp_valid; all outputs are reset values next cycle; the re-presented
//   request is granted.

Source files
------------

// File: rtl/pheap_req_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pheap_req_sched_pkg
// Description : Shared pHeap types for the root-level request scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package pheap_req_sched_pkg;

    typedef enum logic [1:0] {
        LEQ = 2'd0,
        DEQ = 2'd1
    } opcode_t;

    typedef enum logic [1:0] {
        WAIT       = 2'd0,
        NEXT_LEVEL = 2'd1,
        DONE       = 2'd2
    } done_t;

    typedef struct packed {
        logic [15:0] key;
        logic [15:0] value;
    } kv_t;

    // An all-ones key sorts last, so it doubles as the "no entry" marker.
    localparam kv_t KV_EMPTY = '{key: 16'hFFFF, value: 16'h0000};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        GAP   = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/pheap_req_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick of the first request at or
//               after ptr; returns a one-hot grant and its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int w_j;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        w_j   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            w_j = int'(ptr) + i;
            if (w_j >= N) w_j = w_j - N;
            if (req[IW'(w_j)]) begin
                valid = 1'b1;
                idx   = IW'(w_j);
                grant = N'(1) << w_j;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pheap_req_sched.sv
`default_nettype none
// ============================================================================
// Module      : pheap_req_sched
// Description : Round-robin front end for pHeap level 1: screens, issues and
//               paces ENQ/DEQ requests and returns results to the requester.
// Revision    : 1.0 - initial release
// ============================================================================
module pheap_req_sched
    import pheap_req_sched_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int ISSUE_GAP = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  opcode_t         req_op [NREQ],
    input  kv_t             req_kv [NREQ],
    output logic [NREQ-1:0] req_ready,
    output logic [NREQ-1:0] resp_valid,
    output kv_t             resp_kv,
    output logic            resp_err,
    output logic            start,
    output opcode_t         op,
    output kv_t             in,
    input  done_t           done,
    input  kv_t             out,
    input  logic            full,
    input  logic            empty,
    output logic            busy
);

    localparam int c_IW = $clog2(NREQ);
    localparam int c_GW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
    localparam int c_WW = $clog2(TIMEOUT + 1);

    sched_state_t    r_state, w_state_nxt;
    logic [c_IW-1:0] r_rr_ptr, r_gnt_idx;
    opcode_t         r_op;
    kv_t             r_kv;
    logic [c_GW-1:0] r_gap_cnt;
    logic [c_WW-1:0] r_wd_cnt;
    logic [NREQ-1:0] r_resp_valid;
    kv_t             r_resp_kv;
    logic            r_resp_err;

    logic [NREQ-1:0] w_arb_grant;
    logic [c_IW-1:0] w_arb_idx;
    logic            w_arb_valid;
    logic            w_grant_en;
    logic            w_accept;
    opcode_t         w_sel_op;
    logic            w_done_ev;
    logic            w_timeout;
    logic            w_gap_last;

    rr_arbiter #(.N(NREQ), .IW(c_IW)) u_arb (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_arb_grant),
        .idx   (w_arb_idx),
        .valid (w_arb_valid)
    );

    // Holding off grants while a response is out keeps req_ready and
    // resp_valid mutually exclusive even with no issue gap.
    assign w_grant_en = (r_state == IDLE) && !(|r_resp_valid) && !rst && w_arb_valid;
    assign w_sel_op   = req_op[w_arb_idx];
    assign w_accept   = ((w_sel_op == LEQ) && !full) || ((w_sel_op == DEQ) && !empty);
    assign w_done_ev  = (r_state == EXEC) && (done != WAIT);
    assign w_timeout  = (r_state == EXEC) && (done == WAIT) && (r_wd_cnt == c_WW'(TIMEOUT - 1));
    assign w_gap_last = (r_gap_cnt == c_GW'(ISSUE_GAP));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_en) begin
                    if (w_accept)           w_state_nxt = ISSUE;
                    else if (ISSUE_GAP > 0) w_state_nxt = GAP;
                    else                    w_state_nxt = IDLE;
                end
            end
            ISSUE: w_state_nxt = EXEC;
            EXEC: begin
                if (w_done_ev || w_timeout)
                    w_state_nxt = (ISSUE_GAP > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (w_gap_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_gnt_idx    <= '0;
            r_op         <= LEQ;
            r_kv         <= KV_EMPTY;
            r_gap_cnt    <= '0;
            r_wd_cnt     <= '0;
            r_resp_valid <= '0;
            r_resp_kv    <= KV_EMPTY;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= '0;

            if (w_grant_en) begin
                r_gnt_idx <= w_arb_idx;
                r_op      <= w_sel_op;
                r_kv      <= req_kv[w_arb_idx];
                r_rr_ptr  <= (w_arb_idx == c_IW'(NREQ - 1)) ? '0 : w_arb_idx + 1'b1;
                if (!w_accept) begin
                    r_resp_valid <= w_arb_grant;
                    r_resp_err   <= 1'b1;
                    r_resp_kv    <= KV_EMPTY;
                end
            end

            if (r_state == ISSUE) r_wd_cnt <= '0;

            if (r_state == EXEC) begin
                if (w_done_ev) begin
                    r_resp_valid <= NREQ'(1) << r_gnt_idx;
                    r_resp_err   <= 1'b0;
                    r_resp_kv    <= (r_op == DEQ) ? out : KV_EMPTY;
                end else if (w_timeout) begin
                    r_resp_valid <= NREQ'(1) << r_gnt_idx;
                    r_resp_err   <= 1'b1;
                    r_resp_kv    <= KV_EMPTY;
                end else begin
                    r_wd_cnt <= r_wd_cnt + 1'b1;
                end
            end

            if (r_state == GAP) r_gap_cnt <= w_gap_last ? '0 : r_gap_cnt + 1'b1;
            else                r_gap_cnt <= '0;
        end
    end

    // Level 1 ignores op/in without start, so park them at neutral values.
    always_comb begin
        req_ready  = w_grant_en ? w_arb_grant : '0;
        start      = (r_state == ISSUE);
        op         = ((r_state == ISSUE) || (r_state == EXEC)) ? r_op : LEQ;
        in         = ((r_state == ISSUE) || (r_state == EXEC)) ? r_kv : KV_EMPTY;
        busy       = (r_state != IDLE);
        resp_valid = r_resp_valid;
        resp_kv    = r_resp_kv;
        resp_err   = r_resp_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_pheap_req_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_pheap_req_sched
// Description : Scenario bench for pheap_req_sched with a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pheap_req_sched;
    import pheap_req_sched_pkg::*;

    localparam int NREQ      = 4;
    localparam int ISSUE_GAP = 2;
    localparam int TIMEOUT   = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    opcode_t         req_op [NREQ];
    kv_t             req_kv [NREQ];
    logic [NREQ-1:0] req_ready;
    logic [NREQ-1:0] resp_valid;
    kv_t             resp_kv;
    logic            resp_err;
    logic            start;
    opcode_t         l1_op;
    kv_t             l1_in;
    done_t           l1_done;
    kv_t             l1_out;
    logic            full;
    logic            empty;
    logic            busy;

    typedef struct {
        int   idx;
        logic err;
        kv_t  kv;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   n;

    always #5 clk = ~clk;

    pheap_req_sched #(.NREQ(NREQ), .ISSUE_GAP(ISSUE_GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_kv     (req_kv),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_kv    (resp_kv),
        .resp_err   (resp_err),
        .start      (start),
        .op         (l1_op),
        .in         (l1_in),
        .done       (l1_done),
        .out        (l1_out),
        .full       (full),
        .empty      (empty),
        .busy       (busy)
    );

    // Scoreboard: every response must match the oldest expected entry.
    always @(negedge clk) begin
        if (|resp_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected resp_valid=%b expected no response", resp_valid);
            end else begin
                mon_e = sb.pop_front();
                if (resp_valid !== (4'b0001 << mon_e.idx) || resp_err !== mon_e.err || resp_kv !== mon_e.kv) begin
                    n_err++;
                    $display("FAIL sb_resp got valid=%b err=%b kv=%h exp idx=%0d err=%b kv=%h",
                             resp_valid, resp_err, resp_kv, mon_e.idx, mon_e.err, mon_e.kv);
                end
            end
        end
        if ((|resp_valid) || (|req_ready)) begin
            n_vec++;
            if (|(resp_valid & req_ready)) begin
                n_err++;
                $display("FAIL overlap resp_valid=%b req_ready=%b exp disjoint", resp_valid, req_ready);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int idx, output int cnt);
        cnt = 0;
        #1;
        while (!req_ready[idx] && cnt < 40) begin
            cyc();
            #1;
            cnt++;
        end
        if (!req_ready[idx]) begin
            n_vec++;
            n_err++;
            $display("FAIL grant_timeout req_ready=%b exp bit %0d", req_ready, idx);
        end
    endtask

    task automatic l1_exec(input done_t code, input kv_t o, input int waits);
        cyc();
        l1_done = WAIT;
        repeat (waits) cyc();
        l1_done = code;
        l1_out  = o;
        cyc();
        l1_done = WAIT;
        l1_out  = KV_EMPTY;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; l1_done = WAIT; l1_out = KV_EMPTY; full = 1'b0; empty = 1'b0;
        for (int i = 0; i < NREQ; i++) begin req_op[i] = LEQ; req_kv[i] = KV_EMPTY; end
        repeat (3) cyc();
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL rst_start got=%b exp=0", start); end
        n_vec++; if (resp_valid !== 4'b0) begin n_err++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        n_vec++; if (l1_op !== LEQ || l1_in !== KV_EMPTY) begin n_err++; $display("FAIL rst_l1 got op=%0d in=%h exp op=0 in=%h", l1_op, l1_in, KV_EMPTY); end
        n_vec++; if (resp_kv !== KV_EMPTY || resp_err !== 1'b0) begin n_err++; $display("FAIL rst_resp got kv=%h err=%b exp kv=%h err=0", resp_kv, resp_err, KV_EMPTY); end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_leq_basic();
        cyc();
        req_op[0] = LEQ; req_kv[0] = '{key: 16'h0010, value: 16'hA5A5}; req_valid = 4'b0001;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL leq_grant got=%b exp=0001", req_ready); end
        sb.push_back(exp_t'{idx: 0, err: 1'b0, kv: KV_EMPTY});
        cyc(); req_valid = '0; #1;
        n_vec++; if (start !== 1'b1 || l1_op !== LEQ || l1_in.key !== 16'h0010) begin n_err++; $display("FAIL leq_issue got start=%b op=%0d key=%h exp 1/0/0010", start, l1_op, l1_in.key); end
        cyc(); l1_done = DONE; #1;
        n_vec++; if (start !== 1'b0 || l1_in.key !== 16'h0010) begin n_err++; $display("FAIL leq_exec got start=%b key=%h exp 0/0010", start, l1_in.key); end
        cyc(); l1_done = WAIT; #1;
        n_vec++; if (resp_valid !== 4'b0001 || resp_err !== 1'b0) begin n_err++; $display("FAIL leq_resp got valid=%b err=%b exp 0001/0", resp_valid, resp_err); end
    endtask

    task automatic test_rr_pair();
        req_op[1] = LEQ; req_kv[1] = '{key: 16'h0021, value: 16'h0001};
        req_op[3] = LEQ; req_kv[3] = '{key: 16'h0023, value: 16'h0003};
        req_valid = 4'b1010;
        #1;
        n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL rr_resp_cycle_ready got=%b exp=0", req_ready); end
        for (int k = 0; k < ISSUE_GAP; k++) begin
            cyc(); #1;
            n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL rr_gap_ready got=%b exp=0", req_ready); end
        end
        cyc(); #1;
        n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rr_first_grant got=%b exp=0010", req_ready); end
        sb.push_back(exp_t'{idx: 1, err: 1'b0, kv: KV_EMPTY});
        cyc(); req_valid = 4'b1000; #1;
        n_vec++; if (start !== 1'b1 || l1_in.key !== 16'h0021) begin n_err++; $display("FAIL rr_issue1 got start=%b key=%h exp 1/0021", start, l1_in.key); end
        l1_exec(DONE, KV_EMPTY, 0); #1;
        n_vec++; if (resp_valid !== 4'b0010) begin n_err++; $display("FAIL rr_resp1 got=%b exp=0010", resp_valid); end
        wait_grant(3, n);
        n_vec++; if (n !== ISSUE_GAP + 1) begin n_err++; $display("FAIL rr_second_grant_delay got=%0d exp=%0d", n, ISSUE_GAP + 1); end
        sb.push_back(exp_t'{idx: 3, err: 1'b0, kv: KV_EMPTY});
        cyc(); req_valid = '0; #1;
        n_vec++; if (l1_in.key !== 16'h0023) begin n_err++; $display("FAIL rr_issue3 got key=%h exp=0023", l1_in.key); end
        l1_exec(DONE, KV_EMPTY, 1); #1;
        n_vec++; if (resp_valid !== 4'b1000) begin n_err++; $display("FAIL rr_resp3 got=%b exp=1000", resp_valid); end
        n = 0;
        while ((busy || (|resp_valid)) && n < 20) begin cyc(); #1; n++; end
        req_valid = 4'b1111;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rr_ptr_wrap got=%b exp=0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_reject_empty();
        empty = 1'b1; req_op[2] = DEQ; req_valid = 4'b0100;
        wait_grant(2, n);
        sb.push_back(exp_t'{idx: 2, err: 1'b1, kv: KV_EMPTY});
        cyc(); req_valid = '0; #1;
        n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL rej_empty_start got=%b exp=0", start); end
        n_vec++; if (resp_valid !== 4'b0100 || resp_err !== 1'b1 || resp_kv !== KV_EMPTY) begin n_err++; $display("FAIL rej_empty_resp got valid=%b err=%b kv=%h exp 0100/1/%h", resp_valid, resp_err, resp_kv, KV_EMPTY); end
        empty = 1'b0;
    endtask

    task automatic test_reject_full();
        full = 1'b1; req_op[0] = LEQ; req_kv[0] = '{key: 16'h0030, value: 16'h0000}; req_valid = 4'b0001;
        wait_grant(0, n);
        sb.push_back(exp_t'{idx: 0, err: 1'b1, kv: KV_EMPTY});
        cyc(); req_valid = '0; #1;
        n_vec++; if (start !== 1'b0 || resp_valid !== 4'b0001 || resp_err !== 1'b1) begin n_err++; $display("FAIL rej_full got start=%b valid=%b err=%b exp 0/0001/1", start, resp_valid, resp_err); end
    endtask

    task automatic test_deq_full();
        kv_t dq;
        dq = '{key: 16'h0055, value: 16'h1234};
        req_op[0] = DEQ; req_valid = 4'b0001;
        wait_grant(0, n);
        sb.push_back(exp_t'{idx: 0, err: 1'b0, kv: dq});
        cyc(); req_valid = '0; #1;
        n_vec++; if (start !== 1'b1 || l1_op !== DEQ) begin n_err++; $display("FAIL deq_issue got start=%b op=%0d exp 1/1", start, l1_op); end
        l1_exec(NEXT_LEVEL, dq, 1); #1;
        n_vec++; if (resp_kv.key !== 16'h0055 || resp_err !== 1'b0) begin n_err++; $display("FAIL deq_resp got key=%h err=%b exp 0055/0", resp_kv.key, resp_err); end
        full = 1'b0;
    endtask

    task automatic test_timeout();
        req_op[1] = LEQ; req_kv[1] = '{key: 16'h0061, value: 16'h0000}; req_valid = 4'b0010;
        wait_grant(1, n);
        sb.push_back(exp_t'{idx: 1, err: 1'b1, kv: KV_EMPTY});
        cyc(); req_valid = '0; l1_done = WAIT; #1;
        n_vec++; if (start !== 1'b1) begin n_err++; $display("FAIL to_issue got start=%b exp=1", start); end
        for (int k = 1; k <= TIMEOUT; k++) begin
            cyc(); #1;
            n_vec++; if (resp_valid !== 4'b0 || busy !== 1'b1) begin n_err++; $display("FAIL to_wait%0d got valid=%b busy=%b exp 0000/1", k, resp_valid, busy); end
        end
        cyc(); #1;
        n_vec++; if (resp_valid !== 4'b0010 || resp_err !== 1'b1) begin n_err++; $display("FAIL to_resp got valid=%b err=%b exp 0010/1", resp_valid, resp_err); end
        n = 0;
        while (busy && n < 20) begin cyc(); #1; n++; end
        n_vec++; if (n !== ISSUE_GAP + 1) begin n_err++; $display("FAIL to_gap_len got=%0d exp=%0d", n, ISSUE_GAP + 1); end
    endtask

    task automatic test_reset_mid();
        req_op[2] = LEQ; req_kv[2] = '{key: 16'h0042, value: 16'h0000}; req_valid = 4'b0100;
        wait_grant(2, n);
        cyc(); #1;
        n_vec++; if (start !== 1'b1) begin n_err++; $display("FAIL rm_issue got start=%b exp=1", start); end
        cyc(); rst = 1'b1;
        cyc(); #1;
        n_vec++; if (start !== 1'b0 || busy !== 1'b0 || resp_valid !== 4'b0 || req_ready !== 4'b0) begin n_err++; $display("FAIL rm_reset got start=%b busy=%b valid=%b ready=%b exp all 0", start, busy, resp_valid, req_ready); end
        n_vec++; if (l1_op !== LEQ || l1_in !== KV_EMPTY) begin n_err++; $display("FAIL rm_l1 got op=%0d in=%h exp 0/%h", l1_op, l1_in, KV_EMPTY); end
        rst = 1'b0; #1;
        n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rm_regrant got=%b exp=0100", req_ready); end
        sb.push_back(exp_t'{idx: 2, err: 1'b0, kv: KV_EMPTY});
        cyc(); req_valid = '0; #1;
        n_vec++; if (start !== 1'b1 || l1_in.key !== 16'h0042) begin n_err++; $display("FAIL rm_issue2 got start=%b key=%h exp 1/0042", start, l1_in.key); end
        l1_exec(DONE, KV_EMPTY, 0); #1;
        n_vec++; if (resp_valid !== 4'b0100) begin n_err++; $display("FAIL rm_resp got=%b exp=0100", resp_valid); end
    endtask

    initial begin
        test_reset();
        test_leq_basic();
        test_rr_pair();
        test_reject_empty();
        test_reject_full();
        test_deq_full();
        test_timeout();
        test_reset_mid();
        repeat (5) cyc();
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain got=%0d pending exp=0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire
